// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin front end sharing one random number generator among up to four requesters
module rng_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_i,
    input  logic [N*WIDTH-1:0] req_min_i,
    input  logic [N*WIDTH-1:0] req_max_i,
    input  logic [WIDTH-1:0]   rng_num_i,
    output logic [N-1:0]       gnt_o,
    output logic               rsp_valid_o,
    output logic [1:0]         rsp_id_o,
    output logic [WIDTH-1:0]   rsp_data_o,
    output logic               busy_o,
    output logic               rng_en_o,
    output logic [WIDTH-1:0]   rng_min_o,
    output logic [WIDTH-1:0]   rng_max_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GEN  = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       last_id_q, id_q, win, idx;
    logic [3:0]       req_pad;
    logic [WIDTH-1:0] rng_min_q, rng_max_q, rsp_data_q;
    logic [WIDTH-1:0] lo_raw, hi_raw, min_d, hi_sw, max_d;
    logic             grant;

    assign req_pad = 4'(req_i);
    assign grant   = (state_q == IDLE) && |req_i;

    // Round-robin search from one past the last winner; nearest candidate is written last and wins
    always_comb begin
        win = last_id_q;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = 2'((int'(last_id_q) + k) % N);
            if (req_pad[idx]) win = idx;
        end
    end

    assign lo_raw = req_min_i[int'(win)*WIDTH +: WIDTH];
    assign hi_raw = req_max_i[int'(win)*WIDTH +: WIDTH];

    // Order the winner's bounds and keep the full-range case one short so the generator modulus never wraps to zero
    always_comb begin
        min_d = (hi_raw < lo_raw) ? hi_raw : lo_raw;
        hi_sw = (hi_raw < lo_raw) ? lo_raw : hi_raw;
        max_d = (min_d == '0 && hi_sw == '1) ? ~WIDTH'(1) : hi_sw;
    end

    // Only IDLE waits for a request; the rest of the transaction runs unconditionally
    always_comb begin
        state_d = (state_q == IDLE) ? (|req_i ? GEN : IDLE) :
                  (state_q == GEN)  ? CAPT :
                  (state_q == CAPT) ? RESP : IDLE;
    end

    // State, grant bookkeeping and result capture; reset discards any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_id_q  <= 2'(N - 1);
            id_q       <= '0;
            rng_min_q  <= '0;
            rng_max_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_id_q <= win;
                id_q      <= win;
                rng_min_q <= min_d;
                rng_max_q <= max_d;
            end
            if (state_q == CAPT) rsp_data_q <= rng_num_i;
        end
    end

    assign gnt_o       = grant ? N'(1) << win : '0;
    assign rng_en_o    = state_q == GEN;
    assign rsp_valid_o = state_q == RESP;
    assign busy_o      = state_q != IDLE;
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rng_min_o   = rng_min_q;
    assign rng_max_o   = rng_max_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed checks of grant order, bound handling, latency and reset of rng_arbiter
module tb_rng_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] req_min_i = '0;
    logic [N*W-1:0] req_max_i = '0;
    logic [W-1:0]   rng_num_i = '0;
    logic [N-1:0]   gnt_o;
    logic           rsp_valid_o;
    logic [1:0]     rsp_id_o;
    logic [W-1:0]   rsp_data_o;
    logic           busy_o;
    logic           rng_en_o;
    logic [W-1:0]   rng_min_o;
    logic [W-1:0]   rng_max_o;

    logic [W-1:0]   gen_val = '0;
    logic [W-1:0]   got;
    int             tests = 0;
    int             fails = 0;

    rng_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_min_i(req_min_i), .req_max_i(req_max_i),
        .rng_num_i(rng_num_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o), .rng_en_o(rng_en_o), .rng_min_o(rng_min_o),
        .rng_max_o(rng_max_o)
    );

    always #5 clk = ~clk;

    // Generator stand-in: min + value mod (max - min + 1), presented one cycle after rng_en
    always @(posedge clk) begin
        if (rng_en_o) begin
            int span;
            span = int'(rng_max_o) - int'(rng_min_o) + 1;
            if (span <= 0) span = 1;
            rng_num_i <= W'(int'(rng_min_o) + int'(gen_val) % span);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt_o), 0);
        check({tag, "_valid"}, 32'(rsp_valid_o), 0);
        check({tag, "_id"}, 32'(rsp_id_o), 0);
        check({tag, "_data"}, 32'(rsp_data_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_rng_en"}, 32'(rng_en_o), 0);
        check({tag, "_rng_min"}, 32'(rng_min_o), 0);
        check({tag, "_rng_max"}, 32'(rng_max_o), 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_i = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_b(input int i, input logic [W-1:0] mn, input logic [W-1:0] mx);
        req_min_i[i*W +: W] = mn;
        req_max_i[i*W +: W] = mx;
    endtask

    // One full transaction from the IDLE cycle; returns in the following IDLE cycle
    task automatic txn(input logic [N-1:0] r, input bit hold, input int id,
                       input logic [W-1:0] mn, input logic [W-1:0] mx, output logic [W-1:0] data);
        req_i = r;
        #1;
        check("gnt", 32'(gnt_o), 32'(1 << id));
        check("busy_idle", 32'(busy_o), 0);
        step();
        if (!hold) req_i = '0;
        check("rng_en_gen", 32'(rng_en_o), 1);
        check("gnt_gen", 32'(gnt_o), 0);
        check("rng_min", 32'(rng_min_o), 32'(mn));
        check("rng_max", 32'(rng_max_o), 32'(mx));
        check("busy_gen", 32'(busy_o), 1);
        step();
        check("rng_en_capt", 32'(rng_en_o), 0);
        check("valid_capt", 32'(rsp_valid_o), 0);
        step();
        check("valid_resp", 32'(rsp_valid_o), 1);
        check("rsp_id", 32'(rsp_id_o), 32'(id));
        data = rsp_data_o;
        step();
        check("valid_after", 32'(rsp_valid_o), 0);
        check("busy_after", 32'(busy_o), 0);
    endtask

    initial begin
        logic [W-1:0] fr_gen [4] = '{8'd255, 8'd254, 8'd0, 8'd200};
        logic [W-1:0] fr_exp [4] = '{8'd0, 8'd254, 8'd0, 8'd200};
        #2;
        check_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        set_b(0, 8'd10, 8'd19);
        gen_val = 8'hFF;
        txn(4'b0001, 1'b0, 0, 8'd10, 8'd19, got);
        check("basic_data", 32'(got), 15);

        do_reset();
        for (int i = 0; i < N; i++) set_b(i, 8'(i * 10), 8'(i * 10 + 9));
        for (int k = 0; k < 5; k++) begin
            txn(4'b1111, 1'b1, k % 4, 8'((k % 4) * 10), 8'((k % 4) * 10 + 9), got);
            check("rr_data", 32'(got), 32'((k % 4) * 10 + 5));
        end
        req_i = '0;

        set_b(2, 8'd50, 8'd20);
        gen_val = 8'hFF;
        txn(4'b0100, 1'b0, 2, 8'd20, 8'd50, got);
        check("swap_data", 32'(got), 27);
        for (int k = 0; k < 200; k++) begin
            gen_val = W'($urandom);
            txn(4'b0100, 1'b0, 2, 8'd20, 8'd50, got);
            check("swap_range", 32'(got >= 8'd20 && got <= 8'd50), 1);
        end

        set_b(3, 8'd0, 8'd255);
        for (int k = 0; k < 4; k++) begin
            gen_val = fr_gen[k];
            txn(4'b1000, 1'b0, 3, 8'd0, 8'd254, got);
            check("full_data", 32'(got), 32'(fr_exp[k]));
            check("full_known", 32'($isunknown(got)), 0);
        end
        set_b(3, 8'd255, 8'd0);
        gen_val = 8'd253;
        txn(4'b1000, 1'b0, 3, 8'd0, 8'd254, got);
        check("full_swap_data", 32'(got), 253);
        set_b(3, 8'd1, 8'd255);
        gen_val = 8'd254;
        txn(4'b1000, 1'b0, 3, 8'd1, 8'd255, got);
        check("no_clamp_data", 32'(got), 255);

        req_i = 4'b0001;
        #1;
        check("rst_mid_gnt", 32'(gnt_o), 1);
        step();
        req_i = '0;
        step();
        check("rst_mid_in_capt", 32'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        step();
        check("rst_mid_valid", 32'(rsp_valid_o), 0);
        rst_n = 1'b1;
        step();
        check_zero("rst_after");
        set_b(2, 8'd100, 8'd109);
        gen_val = 8'hFF;
        txn(4'b0100, 1'b0, 2, 8'd100, 8'd109, got);
        check("rst_after_data", 32'(got), 105);

        set_b(1, 8'd30, 8'd39);
        gen_val = 8'h10;
        txn(4'b0010, 1'b0, 1, 8'd30, 8'd39, got);
        check("pulse_data", 32'(got), 36);
        for (int k = 0; k < 4; k++) begin
            check("pulse_no_gnt", 32'(gnt_o), 0);
            check("pulse_no_valid", 32'(rsp_valid_o), 0);
            check("pulse_idle", 32'(busy_o), 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
